// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters
//
// Purpose: fetch-stage branch predictor. A direct-mapped table indexed by the
// low PC bits and tagged by the high PC bits holds a valid bit, a stored taken
// target and a saturating direction counter per entry. Lookup is combinational;
// training happens on the rising clock edge from resolved branches.
//
// Optional feature: define BTP_GSHARE_EN to index the counter table by
// (pc index XOR global history) while valid/tag/target stay pc-indexed.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   enable         global enable; low freezes all state (flush included)
//   flush          synchronous invalidate of all entries (beats update)
//   fetch_pc       address being fetched
//   predict_hit    fetch_pc matches a valid entry
//   predict_taken  hit and counter MSB set
//   predict_target stored target on hit, else 0
//   update_valid   resolved branch present this cycle
//   update_pc      address of the resolved branch
//   update_taken   actual outcome
//   update_target  actual taken target
module branch_target_predictor #(
  parameter int PC_WIDTH     = 8,
  parameter int INDEX_BITS   = 4,
  parameter int COUNTER_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                predict_hit,
  output logic                predict_taken,
  output logic [PC_WIDTH-1:0] predict_target,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target
);

  localparam int DEPTH    = 1 << INDEX_BITS;
  localparam int TAG_BITS = PC_WIDTH - INDEX_BITS;

  localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [COUNTER_BITS-1:0] CTR_WNT = CTR_WT - COUNTER_BITS'(1);

  logic                    valid_q  [DEPTH];
  logic [TAG_BITS-1:0]     tag_q    [DEPTH];
  logic [PC_WIDTH-1:0]     target_q [DEPTH];
  logic [COUNTER_BITS-1:0] ctr_q    [DEPTH];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [TAG_BITS-1:0]   upd_tag;
  // Counter-table indices; equal to the pc index unless gshare hashing is on.
  logic [INDEX_BITS-1:0] fetch_cidx;
  logic [INDEX_BITS-1:0] upd_cidx;
  logic                  fetch_hit;
  logic                  upd_hit;
  logic                  do_update;

  function automatic logic [COUNTER_BITS-1:0] ctr_train(
    input logic [COUNTER_BITS-1:0] c,
    input logic                    up
  );
    logic [COUNTER_BITS-1:0] r;
    r = c;
    if (up) begin
      if (c != CTR_MAX) r = c + COUNTER_BITS'(1);
    end else begin
      if (c != '0) r = c - COUNTER_BITS'(1);
    end
    return r;
  endfunction

  assign fetch_idx = fetch_pc[INDEX_BITS-1:0];
  assign fetch_tag = fetch_pc[PC_WIDTH-1:INDEX_BITS];
  assign upd_idx   = update_pc[INDEX_BITS-1:0];
  assign upd_tag   = update_pc[PC_WIDTH-1:INDEX_BITS];

`ifdef BTP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;

  assign fetch_cidx = fetch_idx ^ ghr_q;
  assign upd_cidx   = upd_idx ^ ghr_q;
`else
  assign fetch_cidx = fetch_idx;
  assign upd_cidx   = upd_idx;
`endif

  // Valid bits clear asynchronously on reset, so all outputs drop to zero
  // immediately without extra gating.
  assign fetch_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign predict_hit    = fetch_hit;
  assign predict_taken  = fetch_hit && ctr_q[fetch_cidx][COUNTER_BITS-1];
  assign predict_target = fetch_hit ? target_q[fetch_idx] : '0;

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign do_update = enable && update_valid && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
`ifdef BTP_GSHARE_EN
      ghr_q <= '0;
`endif
    end else if (enable && flush) begin
      // Only valid bits are dropped; counters and targets survive a flush.
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (do_update) begin
      if (upd_hit) begin
        if (update_taken) target_q[upd_idx] <= update_target;
      end else if (update_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target;
      end
`ifdef BTP_GSHARE_EN
      // Counters train on every resolved branch; history indexing uses the
      // pre-shift GHR value.
      ctr_q[upd_cidx] <= ctr_train(ctr_q[upd_cidx], update_taken);
      ghr_q           <= INDEX_BITS'({ghr_q, update_taken});
`else
      if (upd_hit) begin
        ctr_q[upd_cidx] <= ctr_train(ctr_q[upd_cidx], update_taken);
      end else if (update_taken) begin
        ctr_q[upd_cidx] <= CTR_WT;
      end
`endif
    end
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised successor to the pipeline's single-counter branch prediction unit.
- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters, indexed and tagged by fetch PC.
- Sits in FETCH: it drives the predicted direction and target for the next-PC mux. It is trained from DECODE once the branch outcome resolves.
- Adds tagging, stored targets, configurable depth and counter width, and a flush.

Parameters:
- PC_WIDTH, 8, width of instruction addresses.
- INDEX_BITS, 4, log2 of table depth (16 entries); must be < PC_WIDTH.
- COUNTER_BITS, 2, width of each saturating direction counter (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  global pipeline enable; low freezes all state.
- flush  in  1  synchronous invalidate of all BTB entries.
- fetch_pc  in  PC_WIDTH  address being fetched.
- predict_hit  out  1  fetch_pc matches a valid entry.
- predict_taken  out  1  predicted taken.
- predict_target  out  PC_WIDTH  predicted target.
- update_valid  in  1  resolved branch present this cycle.
- update_pc  in  PC_WIDTH  address of resolved branch.
- update_taken  in  1  actual outcome.
- update_target  in  PC_WIDTH  actual taken target.

Behaviour:
- Address split: idx = pc[INDEX_BITS-1:0]; tag = pc[PC_WIDTH-1:INDEX_BITS].
- Entry fields: valid, tag, target, ctr[COUNTER_BITS-1:0].
- Lookup is combinational, zero latency:
  - predict_hit = valid[idx] && tag match.
  - predict_taken = predict_hit && ctr MSB.
  - predict_target = stored target if hit, else 0.
- Lookup returns pre-edge contents. A same-cycle update to the same index is visible on the next cycle only.
- Update occurs at the rising edge when enable && update_valid && !flush:
  - Tag hit, taken: ctr saturating increment, capped at all-ones; target <= update_target.
  - Tag hit, not taken: ctr saturating decrement, floored at 0; target unchanged.
  - Miss, taken: allocate or replace. valid=1, tag, target <= update_target, ctr = weakly taken (1<<(COUNTER_BITS-1)).
  - Miss, not taken: no change.
- Flush: at an edge with enable && flush, every valid bit is cleared. Flush has priority over a same-cycle update; that update is discarded. Counters and targets are kept.
- enable low: no state changes, including flush. Outputs still track fetch_pc combinationally.
- Reset (rst low, async): all valid=0, all ctr = weakly not taken ((1<<(COUNTER_BITS-1))-1), targets/tags=0.
  - Outputs during reset: hit=0, taken=0, target=0.
  - Reset asserted mid-update discards that update.
- COUNTER_BITS=1: the counter is a last-outcome bit. Allocate sets it to 1; the reset value is 0.

Optional Feature:
- Macro: BTP_GSHARE_EN.
- Defined:
  - Adds an INDEX_BITS global history register (GHR), reset to 0.
  - Counter table indexed by pc idx XOR GHR; valid, tag and target remain indexed by pc idx alone.
  - predict_taken = predict_hit && ctr[fetch idx^GHR] MSB.
  - On every enabled update the counter at update idx^GHR is trained, hit or miss, with no allocation gating. In the same edge the GHR updates as GHR <= {GHR[INDEX_BITS-2:0], update_taken}, using the pre-shift value for indexing.
  - Flush does not clear the GHR.
- Undefined: the behaviour above, no GHR logic.

Test Plan:
- Reset, fetch_pc=8'h23 -> predict_hit=0, predict_taken=0, predict_target=8'h00.
- Update pc=8'h23, taken=1, target=8'h40, then fetch 8'h23 -> hit=1, taken=1, target=8'h40. Fetch 8'h33 (same idx, tag mismatch) -> hit=0.
- Four not-taken updates at 8'h23 -> ctr 2->1->0->0 (saturates). taken=0 after the first update, hit stays 1. Two taken updates -> ctr=2, taken=1.
- Update pc=8'h33, taken=1, target=8'h10 -> replaces entry idx 3. Fetch 8'h23 -> hit=0; fetch 8'h33 -> target=8'h10, ctr=2.
- Same cycle update pc=8'h05 and flush=1 -> all hit=0 next cycle; 8'h05 never allocated. enable=0 with update -> no change.
- Same-cycle fetch and update of 8'h07 (empty entry) -> hit=0 that cycle, hit=1 the following cycle. rst low mid-sequence -> all outputs 0 immediately.
